ncl_count_sampler: RTL

//  Clocked consumer of the dual-rail sum digits of the NCL digit-ring counter chain.
//  Per digit: synchronises rails, drives the digit's sumcomp completion acknowledge.

---
 rtl/ncl_count_sampler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ncl_count_sampler.sv
// Clocked sampler for the dual-rail sum digits of an NCL counter ring: synchronises each digit,
// acknowledges it, assembles one binary word per wavefront and checks the count sequence.
module ncl_count_sampler #(
  parameter int DIGITS      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic [2*DIGITS-1:0]   sum,
  output logic [DIGITS-1:0]     sumcomp,
  output logic [DIGITS-1:0]     count,
  output logic                  count_valid,
  input  logic                  count_ready,
  output logic                  err_illegal,
  output logic                  err_nonmono,
  output logic [15:0]           words
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DRAIN} state_t;

  logic [2*DIGITS-1:0] sync_reg [SYNC_STAGES];
  logic [2*DIGITS-1:0] rails;
  state_t              state_reg [DIGITS];
  logic [DIGITS-1:0]   latched_reg;
  logic [DIGITS-1:0]   sumcomp_reg;
  logic [DIGITS-1:0]   count_reg;
  logic [DIGITS-1:0]   prev_reg;
  logic                count_valid_reg;
  logic                err_illegal_reg;
  logic                err_nonmono_reg;
  logic                first_reg;
  logic [15:0]         words_reg;

  logic [DIGITS-1:0]   is_hold;
  logic [DIGITS-1:0]   is_null;
  logic [DIGITS-1:0]   is_data;
  logic [DIGITS-1:0]   is_ill_idle;
  logic                emit;
  logic [DIGITS-1:0]   prev_plus_one;

  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= sum;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign rails = sync_reg[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_decode
      assign is_null[gi]     = (rails[2*gi+1 -: 2] == 2'b00);
      assign is_data[gi]     = ^rails[2*gi+1 -: 2];
      assign is_ill_idle[gi] = (&rails[2*gi+1 -: 2]) && (state_reg[gi] == ST_IDLE);
      assign is_hold[gi]     = (state_reg[gi] == ST_HOLD);
    end
  endgenerate

  // A word can only leave when every digit holds a value and the output slot frees up this cycle.
  assign emit          = (&is_hold) && (!count_valid_reg || count_ready);
  assign prev_plus_one = prev_reg + {{(DIGITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < DIGITS; k++) state_reg[k] <= ST_IDLE;
      sumcomp_reg <= '0;
      latched_reg <= '0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        case (state_reg[k])
          ST_IDLE: begin
            if (is_data[k]) begin
              state_reg[k]   <= ST_HOLD;
              latched_reg[k] <= rails[2*k+1];
              sumcomp_reg[k] <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (emit) state_reg[k] <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (is_null[k]) begin
              state_reg[k]   <= ST_IDLE;
              sumcomp_reg[k] <= 1'b0;
            end
          end
          default: begin
            state_reg[k]   <= ST_IDLE;
            sumcomp_reg[k] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      count_reg       <= '0;
      count_valid_reg <= 1'b0;
      words_reg       <= '0;
      err_illegal_reg <= 1'b0;
      err_nonmono_reg <= 1'b0;
      prev_reg        <= '0;
      first_reg       <= 1'b1;
    end else begin
      if (|is_ill_idle) err_illegal_reg <= 1'b1;
      if (emit) begin
        count_reg       <= latched_reg;
        count_valid_reg <= 1'b1;
        words_reg       <= words_reg + 16'd1;
        prev_reg        <= latched_reg;
        first_reg       <= 1'b0;
        // The first word after init has no predecessor to compare against.
        if (!first_reg && (latched_reg != prev_plus_one)) err_nonmono_reg <= 1'b1;
      end else if (count_ready) begin
        count_valid_reg <= 1'b0;
      end
    end
  end

  assign sumcomp     = sumcomp_reg;
  assign count       = count_reg;
  assign count_valid = count_valid_reg;
  assign err_illegal = err_illegal_reg;
  assign err_nonmono = err_nonmono_reg;
  assign words       = words_reg;

endmodule
